// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life generation sequencer.
// Holds the sequencer state encoding, the neighbour count and the Life rule thresholds.
// No logic; imported by gol_rule and gol_step_ctrl.
package gol_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int NEIGHBOURS_CNT = 8;
  localparam int BIRTH          = 3;  // dead cell with exactly this many live neighbours is born
  localparam int SURVIVE        = 2;  // live cell also survives with exactly this many

endpackage

// File: rtl/gol_rule.sv
// Life rule for one cell: popcount of the 8-neighbour vector plus birth/survive test.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle.
// Ports: i_cell current cell state, i_nbrs neighbour states, o_next state in the next generation.
module gol_rule
  import gol_pkg::*;
(
  input  logic                      i_cell,
  input  logic [NEIGHBOURS_CNT-1:0] i_nbrs,
  output logic                      o_next
);

  logic [3:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
      n = n + 4'(i_nbrs[i]);
    end
    o_next = (n == 4'(BIRTH)) | (i_cell & (n == 4'(SURVIVE)));
  end

endmodule

// File: rtl/gol_step_ctrl.sv
// Generation sequencer: scans the cell RAM one cell per cycle, buffers results in two
// row buffers and writes each row back one row late; grants the RAM port to a host in IDLE.
// Latency: 2*FIELD_W*FIELD_H busy cycles per generation, then a one-cycle o_done pulse.
// Backpressure: host requests are refused (o_host_gnt=0) while busy and must be held;
// i_start is ignored outside IDLE.
// Ports: i_start/o_busy/o_done step control; i_host_* / o_host_* single-cell host access;
// o_ram_* / i_ram_* cell RAM port; o_alive_cnt live cells of the last generation.
// Optional: define GOL_STEP_STATS_EN to enable the live-cell counter (else o_alive_cnt=0).
module gol_step_ctrl
  import gol_pkg::*;
#(
  parameter  int FIELD_W    = 8,
  parameter  int FIELD_H    = 6,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H),
  localparam int CNT_W      = $clog2(FIELD_W * FIELD_H + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  input  logic                      i_host_req,
  input  logic [X_ADR_SIZE-1:0]     i_host_x,
  input  logic [Y_ADR_SIZE-1:0]     i_host_y,
  input  logic                      i_host_we,
  input  logic                      i_host_wdata,
  output logic                      o_host_gnt,
  output logic                      o_host_rdata,
  output logic [X_ADR_SIZE-1:0]     o_ram_x,
  output logic [Y_ADR_SIZE-1:0]     o_ram_y,
  output logic                      o_ram_we,
  output logic                      o_ram_wdata,
  input  logic                      i_ram_cell,
  input  logic [NEIGHBOURS_CNT-1:0] i_ram_nbrs,
  output logic [CNT_W-1:0]          o_alive_cnt
);

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  state_e                  state_q, state_d;
  logic [X_ADR_SIZE-1:0]   x_q, x_d;
  logic [Y_ADR_SIZE-1:0]   y_q, y_d;    // row being computed
  logic [Y_ADR_SIZE-1:0]   wy_q, wy_d;  // row being written back
  logic [1:0][FIELD_W-1:0] rowbuf_q, rowbuf_d;
  logic                    cell_next;

  gol_rule u_rule (
    .i_cell (i_ram_cell),
    .i_nbrs (i_ram_nbrs),
    .o_next (cell_next)
  );

  assign o_busy       = (state_q == ST_CALC) || (state_q == ST_WB);
  assign o_done       = (state_q == ST_DONE);
  assign o_host_rdata = i_ram_cell;

  // Sequence: CALC 0, CALC 1, WB 0, CALC 2, WB 1, ..., CALC H-1, WB H-2, WB H-1, DONE.
  // A row is written only once the row below it has been computed, so every read
  // in CALC still sees the previous generation.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    wy_d        = wy_q;
    o_ram_x     = x_q;
    o_ram_y     = y_q;
    o_ram_we    = 1'b0;
    o_ram_wdata = 1'b0;
    o_host_gnt  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_ram_x     = i_host_x;
        o_ram_y     = i_host_y;
        // start wins over a host request in the same cycle
        o_host_gnt  = i_host_req & ~i_start;
        o_ram_we    = i_host_req & ~i_start & i_host_we;
        o_ram_wdata = i_host_wdata;
        if (i_start) begin
          state_d = ST_CALC;
          x_d     = '0;
          y_d     = '0;
          wy_d    = '0;
        end
      end

      ST_CALC: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == '0) begin
            y_d = Y_ADR_SIZE'(1);
          end else begin
            state_d = ST_WB;
            wy_d    = y_q - Y_ADR_SIZE'(1);
          end
        end else begin
          x_d = x_q + X_ADR_SIZE'(1);
        end
      end

      ST_WB: begin
        o_ram_y     = wy_q;
        o_ram_we    = 1'b1;
        o_ram_wdata = rowbuf_q[wy_q[0]][x_q];
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q < Y_LAST) begin
            state_d = ST_CALC;
            y_d     = y_q + Y_ADR_SIZE'(1);
          end else if (wy_q < Y_LAST) begin
            // last row has been computed but not yet written
            wy_d = Y_LAST;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          x_d = x_q + X_ADR_SIZE'(1);
        end
      end

      ST_DONE: begin
        o_ram_x = '0;
        o_ram_y = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rowbuf_d = rowbuf_q;
    if (state_q == ST_CALC) begin
      rowbuf_d[y_q[0]][x_q] = cell_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      wy_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wy_q    <= wy_d;
    end
  end

  // Row buffers are always fully rewritten in CALC before being read, so no reset.
  always_ff @(posedge clk) begin
    rowbuf_q <= rowbuf_d;
  end

`ifdef GOL_STEP_STATS_EN
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] alive_q, alive_d;

  always_comb begin
    acc_d   = acc_q;
    alive_d = alive_q;
    if ((state_q == ST_IDLE) && i_start) begin
      acc_d = '0;
    end else if ((state_q == ST_CALC) && cell_next) begin
      acc_d = acc_q + CNT_W'(1);
    end
    if (state_q == ST_DONE) begin
      alive_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      alive_q <= '0;
    end else begin
      acc_q   <= acc_d;
      alive_q <= alive_d;
    end
  end

  assign o_alive_cnt = alive_q;
`else
  assign o_alive_cnt = '0;
`endif

endmodule
